// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - shared constants, opcodes and FSM states for the logic-op arbiter
package logic_op_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational 8-bit bitwise logic unit shared by both requesters
module logic_unit
    import logic_op_pkg::*;
(
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_NOT:  y_o = ~a_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - two-requester round-robin arbiter in front of one shared logic unit
module logic_op_arbiter
    import logic_op_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iReq0_valid,
    output logic              oReq0_ready,
    input  logic [1:0]        iReq0_op,
    input  logic [DATA_W-1:0] iReq0_a,
    input  logic [DATA_W-1:0] iReq0_b,
    input  logic              iReq1_valid,
    output logic              oReq1_ready,
    input  logic [1:0]        iReq1_op,
    input  logic [DATA_W-1:0] iReq1_a,
    input  logic [DATA_W-1:0] iReq1_b,
    output logic              oRsp0_valid,
    output logic [DATA_W-1:0] oRsp0_data,
    input  logic              iRsp0_ready,
    output logic              oRsp1_valid,
    output logic [DATA_W-1:0] oRsp1_data,
    input  logic              iRsp1_ready,
    output logic              oBusy,
    output logic [CNT_W-1:0]  oDoneCnt
);

    state_e              state_q;
    logic                owner_q;
    logic                last_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   result_q;
    logic [1:0]          rsp_valid_q;
    logic [CNT_W-1:0]    done_cnt_q;
    logic [CNT_W-1:0]    done_cnt_d;

    logic                winner;
    logic                idle_ok;
    logic                grant;
    logic                rsp_hs;
    logic [DATA_W-1:0]   alu_y;

    // With both requesting, the one not served last wins; otherwise the lone requester does.
    assign winner  = (iReq0_valid && iReq1_valid) ? ~last_q : ~iReq0_valid;
    assign idle_ok = (state_q == ST_IDLE) && iRst_n;

    assign oReq0_ready = idle_ok && iReq0_valid && !winner;
    assign oReq1_ready = idle_ok && iReq1_valid &&  winner;
    assign grant       = oReq0_ready || oReq1_ready;

    assign rsp_hs = owner_q ? (rsp_valid_q[1] && iRsp1_ready)
                            : (rsp_valid_q[0] && iRsp0_ready);

    assign done_cnt_d = done_cnt_q + 1'b1;

    logic_unit u_logic_unit (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            rsp_valid_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= winner;
                        op_q    <= winner ? iReq1_op : iReq0_op;
                        a_q     <= winner ? iReq1_a  : iReq0_a;
                        b_q     <= winner ? iReq1_b  : iReq0_b;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_y;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= '0;
                        last_q      <= owner_q;
                        done_cnt_q  <= done_cnt_d;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oRsp0_valid = rsp_valid_q[0];
    assign oRsp1_valid = rsp_valid_q[1];
    assign oRsp0_data  = rsp_valid_q[0] ? result_q : '0;
    assign oRsp1_data  = rsp_valid_q[1] ? result_q : '0;
    assign oBusy       = (state_q != ST_IDLE);
    assign oDoneCnt    = done_cnt_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - directed self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iReq0_valid, iReq1_valid;
    logic        oReq0_ready, oReq1_ready;
    logic [1:0]  iReq0_op, iReq1_op;
    logic [7:0]  iReq0_a, iReq0_b, iReq1_a, iReq1_b;
    logic        oRsp0_valid, oRsp1_valid;
    logic [7:0]  oRsp0_data, oRsp1_data;
    logic        iRsp0_ready, iRsp1_ready;
    logic        oBusy;
    logic [15:0] oDoneCnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 iClk = ~iClk;

    logic_op_arbiter dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iReq0_valid(iReq0_valid), .oReq0_ready(oReq0_ready),
        .iReq0_op(iReq0_op), .iReq0_a(iReq0_a), .iReq0_b(iReq0_b),
        .iReq1_valid(iReq1_valid), .oReq1_ready(oReq1_ready),
        .iReq1_op(iReq1_op), .iReq1_a(iReq1_a), .iReq1_b(iReq1_b),
        .oRsp0_valid(oRsp0_valid), .oRsp0_data(oRsp0_data), .iRsp0_ready(iRsp0_ready),
        .oRsp1_valid(oRsp1_valid), .oRsp1_data(oRsp1_data), .iRsp1_ready(iRsp1_ready),
        .oBusy(oBusy), .oDoneCnt(oDoneCnt)
    );

    task automatic step();
        @(posedge iClk);
        #2;
    endtask

    task automatic idle_inputs();
        iReq0_valid = 0; iReq1_valid = 0;
        iReq0_op = 0; iReq0_a = 0; iReq0_b = 0;
        iReq1_op = 0; iReq1_a = 0; iReq1_b = 0;
        iRsp0_ready = 0; iRsp1_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iRst_n = 0;
        step();
        iRst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        iReq0_valid = 1; iReq1_valid = 1;
        iRst_n = 0;
        #1;
        n_tests++; if (oReq0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", oReq0_ready); end
        n_tests++; if (oReq1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", oReq1_ready); end
        step(); step();
        n_tests++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
        n_tests++; if (oDoneCnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", oDoneCnt); end
        n_tests++; if ({oRsp0_valid, oRsp1_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", {oRsp0_valid, oRsp1_valid}); end
        n_tests++; if ({oRsp0_data, oRsp1_data} !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0000", {oRsp0_data, oRsp1_data}); end
        idle_inputs();
        iRst_n = 1;
        step();
    endtask

    task automatic test_basic_and();
        do_reset();
        iReq0_valid = 1; iReq0_op = 2'b00; iReq0_a = 8'hF0; iReq0_b = 8'h3C;
        #1;
        n_tests++; if (oReq0_ready !== 1'b1) begin n_fail++; $display("FAIL and_ready0: got %b expected 1", oReq0_ready); end
        n_tests++; if (oReq1_ready !== 1'b0) begin n_fail++; $display("FAIL and_ready1: got %b expected 0", oReq1_ready); end
        step();
        iReq0_valid = 0;
        #1;
        n_tests++; if (oRsp0_valid !== 1'b0) begin n_fail++; $display("FAIL and_exec_rsp: got %b expected 0", oRsp0_valid); end
        n_tests++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL and_exec_busy: got %b expected 1", oBusy); end
        step();
        #1;
        n_tests++; if (oRsp0_valid !== 1'b1) begin n_fail++; $display("FAIL and_rsp_valid: got %b expected 1", oRsp0_valid); end
        n_tests++; if (oRsp0_data !== 8'h30) begin n_fail++; $display("FAIL and_rsp_data: got %h expected 30", oRsp0_data); end
        n_tests++; if (oRsp1_valid !== 1'b0) begin n_fail++; $display("FAIL and_rsp1_valid: got %b expected 0", oRsp1_valid); end
        iRsp0_ready = 1;
        step();
        iRsp0_ready = 0;
        #1;
        n_tests++; if (oDoneCnt !== 16'd1) begin n_fail++; $display("FAIL and_cnt: got %h expected 0001", oDoneCnt); end
        n_tests++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL and_idle_busy: got %b expected 0", oBusy); end
        n_tests++; if (oRsp0_data !== 8'h00) begin n_fail++; $display("FAIL and_data_cleared: got %h expected 00", oRsp0_data); end
    endtask

    task automatic test_alternate();
        do_reset();
        iReq0_valid = 1; iReq0_op = 2'b01; iReq0_a = 8'h0F; iReq0_b = 8'hA0;
        iReq1_valid = 1; iReq1_op = 2'b11; iReq1_a = 8'hFF; iReq1_b = 8'h0F;
        iRsp0_ready = 1; iRsp1_ready = 1;
        for (int k = 0; k < 12; k++) begin
            int  phase;
            bit  own;
            phase = k % 3;
            own   = ((k / 3) % 2) == 1;
            #1;
            if (phase == 0) begin
                n_tests++; if ({oReq1_ready, oReq0_ready} !== {own, ~own}) begin n_fail++; $display("FAIL alt_grant k=%0d: got %b expected %b", k, {oReq1_ready, oReq0_ready}, {own, ~own}); end
            end else if (phase == 1) begin
                n_tests++; if ({oReq1_ready, oReq0_ready} !== 2'b00) begin n_fail++; $display("FAIL alt_exec_ready k=%0d: got %b expected 00", k, {oReq1_ready, oReq0_ready}); end
            end else begin
                n_tests++; if ({oRsp1_valid, oRsp0_valid} !== {own, ~own}) begin n_fail++; $display("FAIL alt_rsp_valid k=%0d: got %b expected %b", k, {oRsp1_valid, oRsp0_valid}, {own, ~own}); end
                n_tests++;
                if (own) begin
                    if ({oRsp1_data, oRsp0_data} !== 16'hF000) begin n_fail++; $display("FAIL alt_rsp_data k=%0d: got %h expected F000", k, {oRsp1_data, oRsp0_data}); end
                end else begin
                    if ({oRsp1_data, oRsp0_data} !== 16'h00AF) begin n_fail++; $display("FAIL alt_rsp_data k=%0d: got %h expected 00AF", k, {oRsp1_data, oRsp0_data}); end
                end
            end
            step();
        end
        idle_inputs();
        #1;
        n_tests++; if (oDoneCnt !== 16'd4) begin n_fail++; $display("FAIL alt_cnt: got %h expected 0004", oDoneCnt); end
        step();
    endtask

    task automatic test_hold_not();
        do_reset();
        iReq1_valid = 1; iReq1_op = 2'b10; iReq1_a = 8'h5A; iReq1_b = 8'hFF;
        #1;
        n_tests++; if ({oReq1_ready, oReq0_ready} !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b expected 10", {oReq1_ready, oReq0_ready}); end
        step();
        iReq1_valid = 0;
        iReq0_valid = 1; iReq0_op = 2'b00; iReq0_a = 8'h11; iReq0_b = 8'h22;
        #1;
        n_tests++; if (oReq0_ready !== 1'b0) begin n_fail++; $display("FAIL hold_exec_ready0: got %b expected 0", oReq0_ready); end
        step();
        iRsp0_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if ({oRsp1_valid, oRsp1_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL hold_rsp1 cyc=%0d: got %b/%h expected 1/A5", i, oRsp1_valid, oRsp1_data); end
            n_tests++; if ({oRsp0_valid, oReq0_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_other cyc=%0d: got %b expected 00", i, {oRsp0_valid, oReq0_ready}); end
            step();
        end
        iRsp0_ready = 0;
        iRsp1_ready = 1;
        step();
        iRsp1_ready = 0;
        #1;
        n_tests++; if (oReq0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_waiter_granted: got %b expected 1", oReq0_ready); end
        n_tests++; if (oDoneCnt !== 16'd1) begin n_fail++; $display("FAIL hold_cnt: got %h expected 0001", oDoneCnt); end
        iReq0_valid = 0;
        step();
        #1;
        n_tests++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL hold_drop_busy: got %b expected 0", oBusy); end
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        iReq0_valid = 1; iReq0_op = 2'b01; iReq0_a = 8'h11; iReq0_b = 8'h22;
        step();
        iReq0_valid = 0;
        step();
        #1;
        n_tests++; if ({oRsp0_valid, oRsp0_data} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL rir_rsp: got %b/%h expected 1/33", oRsp0_valid, oRsp0_data); end
        iRst_n = 0;
        step();
        iRst_n = 1;
        #1;
        n_tests++; if ({oRsp0_valid, oRsp0_data} !== 9'h000) begin n_fail++; $display("FAIL rir_rsp_cleared: got %b/%h expected 0/00", oRsp0_valid, oRsp0_data); end
        n_tests++; if ({oBusy, oDoneCnt} !== 17'h0) begin n_fail++; $display("FAIL rir_state: got busy=%b cnt=%h expected 0/0000", oBusy, oDoneCnt); end
        iReq0_valid = 1; iReq0_op = 2'b11; iReq0_a = 8'h12; iReq0_b = 8'h34;
        #1;
        n_tests++; if (oReq0_ready !== 1'b1) begin n_fail++; $display("FAIL rir_next_ready: got %b expected 1", oReq0_ready); end
        step();
        iReq0_valid = 0;
        step();
        #1;
        n_tests++; if ({oRsp0_valid, oRsp0_data} !== {1'b1, 8'h26}) begin n_fail++; $display("FAIL rir_next_rsp: got %b/%h expected 1/26", oRsp0_valid, oRsp0_data); end
        iRsp0_ready = 1;
        step();
        iRsp0_ready = 0;
        #1;
        n_tests++; if (oDoneCnt !== 16'd1) begin n_fail++; $display("FAIL rir_cnt: got %h expected 0001", oDoneCnt); end
    endtask

    task automatic test_drop_while_busy();
        do_reset();
        iReq1_valid = 1; iReq1_op = 2'b01; iReq1_a = 8'h01; iReq1_b = 8'h02;
        #1;
        n_tests++; if (oReq1_ready !== 1'b1) begin n_fail++; $display("FAIL drop_grant1: got %b expected 1", oReq1_ready); end
        step();
        iReq1_valid = 0;
        iReq0_valid = 1; iReq0_op = 2'b00; iReq0_a = 8'hFF; iReq0_b = 8'hFF;
        #1;
        n_tests++; if (oReq0_ready !== 1'b0) begin n_fail++; $display("FAIL drop_busy_ready0: got %b expected 0", oReq0_ready); end
        step();
        iReq0_valid = 0;
        #1;
        n_tests++; if ({oRsp1_valid, oRsp1_data, oRsp0_valid} !== {1'b1, 8'h03, 1'b0}) begin n_fail++; $display("FAIL drop_rsp1: got %b/%h/%b expected 1/03/0", oRsp1_valid, oRsp1_data, oRsp0_valid); end
        iRsp1_ready = 1;
        step();
        iRsp1_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if ({oRsp0_valid, oBusy, oReq0_ready} !== 3'b000) begin n_fail++; $display("FAIL drop_no_accept cyc=%0d: got %b expected 000", i, {oRsp0_valid, oBusy, oReq0_ready}); end
            step();
        end
        #1;
        n_tests++; if (oDoneCnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %h expected 0001", oDoneCnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.done_cnt_q = 16'hFFFF;
        #1;
        release dut.done_cnt_q;
        for (int r = 0; r < 2; r++) begin
            iReq0_valid = 1; iReq0_op = 2'b00; iReq0_a = 8'hAA; iReq0_b = 8'h0F;
            step();
            iReq0_valid = 0;
            step();
            #1;
            n_tests++; if (oRsp0_data !== 8'h0A) begin n_fail++; $display("FAIL wrap_data r=%0d: got %h expected 0A", r, oRsp0_data); end
            iRsp0_ready = 1;
            step();
            iRsp0_ready = 0;
            #1;
            n_tests++; if (oDoneCnt !== 16'(r)) begin n_fail++; $display("FAIL wrap_cnt r=%0d: got %h expected %h", r, oDoneCnt, 16'(r)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_basic_and();
        test_alternate();
        test_hold_not();
        test_reset_in_resp();
        test_drop_while_busy();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
